// File: rtl/rs232_rx_ovs.sv
// RS-232 receiver with 16x oversampling, 2-of-3 majority voting per bit and a
// valid/ready output register. Define RS232_PARITY_EN for 8E1 frames (default 8N1).
module rs232_rx_ovs #(
    parameter int OVS_DIV = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rxd_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       frame_err_out,
    output logic       overrun_out,
    output logic       parity_err_out
);

    localparam int DIV_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OVS_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef RS232_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic             rxd_meta_q, rxd_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       sample_q, sample_d;
    logic             s7_q, s7_d, s8_q, s8_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             tick, maj, frame_done;
`ifdef RS232_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    assign tick = (div_q == DIV_LAST);
    // Vote over ticks 7 and 8 (held) and the live sample at tick 9.
    assign maj  = (s7_q & s8_q) | (s7_q & rxd_sync_q) | (s8_q & rxd_sync_q);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + 1'b1;
        sample_d    = tick ? sample_q + 4'd1 : sample_q;
        s7_d        = (tick && sample_q == 4'd7) ? rxd_sync_q : s7_q;
        s8_d        = (tick && sample_q == 4'd8) ? rxd_sync_q : s8_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_done  = 1'b0;
        frame_err_d = 1'b0;
`ifdef RS232_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                sample_d = '0;
                if (!rxd_sync_q) begin
                    state_d = S_START;
                    div_d   = '0;
`ifdef RS232_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_START: begin
                if (tick && sample_q == 4'd9 && maj) begin
                    state_d = S_IDLE;
                end else if (tick && sample_q == 4'd15) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (tick && sample_q == 4'd9) begin
                    shift_d = {maj, shift_q[7:1]};
                end
                if (tick && sample_q == 4'd15) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef RS232_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef RS232_PARITY_EN
            S_PARITY: begin
                if (tick && sample_q == 4'd9) begin
                    par_bad_d    = maj ^ (^shift_q);
                    parity_err_d = maj ^ (^shift_q);
                end
                if (tick && sample_q == 4'd15) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-bit so a following start edge is never missed.
                if (tick && sample_q == 4'd9) begin
                    state_d  = S_IDLE;
                    sample_d = '0;
                    if (maj) begin
`ifdef RS232_PARITY_EN
                        frame_done = !par_bad_q;
`else
                        frame_done = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end
        if (frame_done) begin
            if (!valid_q || ready_in) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rxd_meta_q  <= 1'b1;
            rxd_sync_q  <= 1'b1;
            state_q     <= S_IDLE;
            div_q       <= '0;
            sample_q    <= '0;
            s7_q        <= 1'b1;
            s8_q        <= 1'b1;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef RS232_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rxd_meta_q  <= rxd_in;
            rxd_sync_q  <= rxd_meta_q;
            state_q     <= state_d;
            div_q       <= div_d;
            sample_q    <= sample_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef RS232_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_out      = data_q;
    assign valid_out     = valid_q;
    assign frame_err_out = frame_err_q;
    assign overrun_out   = overrun_q;
`ifdef RS232_PARITY_EN
    assign parity_err_out = parity_err_q;
`else
    assign parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_rs232_rx_ovs.sv
// Directed bench for rs232_rx_ovs: clean frame, glitch, framing error,
// overrun, async reset, mid-frame reset and (with RS232_PARITY_EN) parity error.
module tb_rs232_rx_ovs;

    localparam int OVS_DIV = 4;
    localparam int BIT     = 16 * OVS_DIV;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       rxd_in = 1'b1;
    logic       ready_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out, frame_err_out, overrun_out, parity_err_out;

    int checks   = 0;
    int failures = 0;

    int valid_cyc = 0, acc_cnt = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, dbl_cnt = 0;
    logic [7:0] acc_data = 8'h00;
    logic fe_prev = 1'b0, ov_prev = 1'b0, pe_prev = 1'b0;

    rs232_rx_ovs #(.OVS_DIV(OVS_DIV)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rxd_in        (rxd_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .frame_err_out (frame_err_out),
        .overrun_out   (overrun_out),
        .parity_err_out(parity_err_out)
    );

    always #5 clk_in = ~clk_in;

    // Event counters sampled mid-cycle; pulses longer than one cycle are tallied in dbl_cnt.
    always @(negedge clk_in) begin
        if (valid_out) valid_cyc <= valid_cyc + 1;
        if (valid_out && ready_in) begin
            acc_cnt  <= acc_cnt + 1;
            acc_data <= data_out;
        end
        if (frame_err_out) fe_cnt <= fe_cnt + 1;
        if (overrun_out)   ov_cnt <= ov_cnt + 1;
        if (parity_err_out) pe_cnt <= pe_cnt + 1;
        if ((frame_err_out && fe_prev) || (overrun_out && ov_prev) || (parity_err_out && pe_prev))
            dbl_cnt <= dbl_cnt + 1;
        fe_prev <= frame_err_out;
        ov_prev <= overrun_out;
        pe_prev <= parity_err_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_bit(input logic b);
        rxd_in = b;
        wait_cycles(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RS232_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_b);
        rxd_in = 1'b1;
    endtask

    int v0, a0, f0, o0, p0;

    task automatic snap();
        v0 = valid_cyc; a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
    endtask

    initial begin
        wait_cycles(3);
        check("rst_data",   32'(data_out), 32'h00);
        check("rst_valid",  32'(valid_out), 32'h0);
        check("rst_ferr",   32'(frame_err_out), 32'h0);
        check("rst_ovr",    32'(overrun_out), 32'h0);
        check("rst_perr",   32'(parity_err_out), 32'h0);
        rst_in = 1'b0;
        wait_cycles(10);

        // Clean 0xA5, consumer always ready.
        ready_in = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1);
        wait_cycles(BIT);
        check("a5_valid_cycles", 32'(valid_cyc - v0), 32'd1);
        check("a5_accepts",      32'(acc_cnt - a0), 32'd1);
        check("a5_data",         32'(acc_data), 32'hA5);
        check("a5_ferr",         32'(fe_cnt - f0), 32'd0);
        check("a5_ovr",          32'(ov_cnt - o0), 32'd0);

        // 20-cycle low glitch is a false start.
        snap();
        rxd_in = 1'b0;
        wait_cycles(20);
        rxd_in = 1'b1;
        wait_cycles(3 * BIT);
        check("glitch_valid", 32'(valid_cyc - v0), 32'd0);
        check("glitch_ferr",  32'(fe_cnt - f0), 32'd0);
        check("glitch_ovr",   32'(ov_cnt - o0), 32'd0);

        // 0x3C with a low stop bit.
        snap();
        send_frame(8'h3C, 1'b0);
        wait_cycles(3 * BIT);
        check("3c_ferr",  32'(fe_cnt - f0), 32'd1);
        check("3c_valid", 32'(valid_cyc - v0), 32'd0);

        // Back-to-back 0x11, 0x22 with consumer stalled.
        ready_in = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cycles(BIT);
        check("ovr_data",  32'(data_out), 32'h11);
        check("ovr_valid", 32'(valid_out), 32'h1);
        check("ovr_count", 32'(ov_cnt - o0), 32'd1);
        ready_in = 1'b1;
        wait_cycles(1);
        check("ovr_valid_clr", 32'(valid_out), 32'h0);
        wait_cycles(2);
        check("ovr_acc_data", 32'(acc_data), 32'h11);

        // Asynchronous reset clears a held byte between clock edges.
        ready_in = 1'b0;
        send_frame(8'h42, 1'b1);
        wait_cycles(BIT);
        check("pre_rst_valid", 32'(valid_out), 32'h1);
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_valid", 32'(valid_out), 32'h0);
        check("async_rst_data",  32'(data_out), 32'h00);
        wait_cycles(3);
        rst_in = 1'b0;
        wait_cycles(10);

        // Reset mid-way through bit 4 of 0xFF, then a clean 0x5A.
        ready_in = 1'b1;
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rxd_in = 1'b1;
        wait_cycles(BIT / 2);
        rst_in = 1'b1;
        wait_cycles(5);
        rst_in = 1'b0;
        wait_cycles(2 * BIT);
        send_frame(8'h5A, 1'b1);
        wait_cycles(BIT);
        check("rst_mid_accepts", 32'(acc_cnt - a0), 32'd1);
        check("rst_mid_data",    32'(acc_data), 32'h5A);

`ifdef RS232_PARITY_EN
        // 0x07 has odd weight; a parity bit of 0 violates even parity.
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h07 >> i) & 8'h01) != 0);
        send_bit(1'b0);
        send_bit(1'b1);
        wait_cycles(BIT);
        check("par_err_count", 32'(pe_cnt - p0), 32'd1);
        check("par_valid",     32'(valid_cyc - v0), 32'd0);
`else
        check("no_parity_pulses", 32'(pe_cnt), 32'd0);
`endif

        check("single_cycle_pulses", 32'(dbl_cnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs232_rx_ovs.md
RS232_RX_OVS -- requirements
Module: rs232_rx_ovs

Interface
REQ-001 The module SHALL have parameter OVS_DIV, default 4, meaning clk_in cycles per 1/16-bit oversample tick (bit period = 16*OVS_DIV cycles).
REQ-002 The module SHALL have port clk_in, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_in, input, 1, reset, asynchronous and active-high.
REQ-004 The module SHALL have port rxd_in, input, 1, asynchronous serial line; idles high.
REQ-005 The module SHALL have port data_out, output, 8, received byte held for the consumer.
REQ-006 The module SHALL have port valid_out, output, 1, data_out holds an unconsumed byte.
REQ-007 The module SHALL have port ready_in, input, 1, consumer accepts data_out when high with valid_out.
REQ-008 The module SHALL have port frame_err_out, output, 1, one-cycle pulse on a bad stop bit.
REQ-009 The module SHALL have port overrun_out, output, 1, one-cycle pulse when a completed byte is dropped.
REQ-010 The module SHALL have port parity_err_out, output, 1, one-cycle pulse on a parity mismatch.

Function
REQ-011 rxd_in SHALL pass through a 2-flop synchronizer reset to 1; all logic uses the synchronized value.
REQ-012 A tick counter SHALL pulse every OVS_DIV cycles, free-running and cleared on leaving IDLE; a 4-bit sample counter SHALL count ticks 0..15 per bit and wrap 15->0.
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronized rxd low.
REQ-014 Each bit value SHALL be the 2-of-3 majority of samples at ticks 7, 8, 9.
REQ-015 START: a majority of 1 at tick 9 SHALL return to IDLE with no output (false start); a majority of 0 SHALL enter DATA at tick 15 wrap.
REQ-016 DATA SHALL shift 8 bits LSB first, bit index 0..7, advancing at each tick-15 wrap; after bit 7 go to PARITY if enabled, else STOP.
REQ-017 STOP: at tick 9, majority 1 SHALL complete the frame; majority 0 SHALL pulse frame_err_out, discard the byte, and not assert valid_out.
REQ-018 After STOP evaluation the FSM SHALL return to IDLE at tick 9 (not wait for tick 15), so back-to-back frames with half-bit skew are received.
REQ-019 On frame completion with valid_out=0, data_out and valid_out=1 SHALL load on the next clock edge (latency: 1 cycle after the stop-bit tick 9).
REQ-020 Handshake: valid_out SHALL clear on the edge where valid_out=1 and ready_in=1; data_out SHALL stay stable while valid_out=1 and not accepted.
REQ-021 If a frame completes while valid_out=1 and ready_in=0, the new byte SHALL be dropped, overrun_out pulses, and data_out is unchanged.
REQ-022 If a frame completes in the same cycle as an accept, the new byte SHALL load, valid_out stays 1, and there is no overrun.
REQ-023 frame_err_out, overrun_out, and parity_err_out SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-024 rst_in high SHALL force IDLE, counters 0, synchronizer 1, data_out 8'h00, and all of valid_out, frame_err_out, overrun_out, parity_err_out to 0, immediately and independent of clk_in.
REQ-025 Reset mid-frame SHALL discard the partial byte; after release the block SHALL resynchronize on the next falling edge of rxd_in.

Configuration
REQ-026 Macro RS232_PARITY_EN defined: frames are 8E1; PARITY state samples one even-parity bit, and on mismatch pulses parity_err_out and discards the byte (the stop bit is still checked).
REQ-027 Macro RS232_PARITY_EN undefined: frames are 8N1; the PARITY state is absent and parity_err_out is tied 0.

Verification
REQ-028 OVS_DIV=4, 8N1, send 8'hA5 with ready_in=1 -> valid_out high exactly 1 cycle, data_out=8'hA5, no error pulses.
REQ-029 Low glitch of 20 cycles on idle rxd_in -> the FSM returns to IDLE; valid_out and all error outputs stay 0.
REQ-030 Send 8'h3C with the stop bit driven 0 -> one frame_err_out pulse; valid_out stays 0.
REQ-031 Send 8'h11 then 8'h22 back-to-back with ready_in=0 -> data_out=8'h11 and valid_out=1, overrun_out pulses once; after ready_in=1, valid_out clears.
REQ-032 Assert rst_in at DATA bit 4 of 8'hFF, release, then send 8'h5A -> only 8'h5A is delivered.
REQ-033 RS232_PARITY_EN defined, send 8'h07 with parity bit 0 -> parity_err_out pulses once; no valid_out.
